// File: rtl/cpu_out_tracer.sv
// Purpose: passive trace logger. It samples the processor out bus and the I/Z/S/HALT
//          flags on every clock and writes a timestamped entry to a FIFO whenever any
//          of them changes. Capture stops after HALT, and the host drains the FIFO.
// Latency: 1 cycle from the sampling edge until the entry appears at rd_data/rd_valid
//          when the FIFO was empty.
// Backpressure: rd_valid/rd_ready handshake on the read side. While the FIFO is full,
//          new events are dropped and counted in overflow/dropped. The shadow register
//          still advances, so a dropped value is not logged again.
//
// Ports:
//   clk, reset          - rising-edge clock; asynchronous active-high reset
//   cpu_out, cpu_i/z/s  - observed processor output bus and flags
//   cpu_halt            - processor HALT; the entry for it is the last one captured
//   rd_valid/rd_ready   - read handshake for the FIFO head
//   rd_data             - {timestamp, halt, s, z, i, out}, registered head entry
//   count               - FIFO occupancy, 0..DEPTH
//   overflow, dropped   - sticky drop flag and saturating drop counter
//   done                - capture halted and FIFO fully drained
module cpu_out_tracer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int TS_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          cpu_out,
    input  logic                 cpu_i,
    input  logic                 cpu_z,
    input  logic                 cpu_s,
    input  logic                 cpu_halt,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [TS_W+19:0]     rd_data,
    output logic [ADDR_W:0]      count,
    output logic                 overflow,
    output logic [7:0]           dropped,
    output logic                 done
);

    localparam int EW = TS_W + 20;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [TS_W-1:0] TS_ONE   = TS_W'(1);

    typedef enum logic {
        ST_CAPTURE = 1'b0,
        ST_HALTED  = 1'b1
    } state_t;

    // Registered state
    state_t          r_state;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic [TS_W-1:0] r_ts;
    logic [19:0]     r_shadow;
    logic            r_first;
    logic            r_rd_valid;
    logic [EW-1:0]   r_rd_data;
    logic            r_overflow;
    logic [7:0]      r_dropped;
    logic            r_done;

    // Combinational next-state terms
    logic [19:0]     w_sample;
    logic [EW-1:0]   w_entry;
    logic [ADDR_W:0] w_count;
    logic [ADDR_W:0] w_count_nxt;
    logic            w_full;
    logic            w_capture;
    logic            w_event;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [ADDR_W:0] w_wr_ptr_nxt;
    logic [ADDR_W:0] w_rd_ptr_nxt;
    logic            w_bypass;
    logic [EW-1:0]   w_head_nxt;
    state_t          w_state_nxt;

    assign w_sample  = {cpu_halt, cpu_s, cpu_z, cpu_i, cpu_out};
    assign w_entry   = {r_ts, w_sample};

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_count == FULL_CNT);

    assign w_capture = (r_state == ST_CAPTURE);
    assign w_event   = w_capture && (r_first || (w_sample != r_shadow));
    assign w_pop     = r_rd_valid && rd_ready;

    // A full FIFO still accepts an entry when a pop frees a slot on the same edge.
    assign w_push    = w_event && (!w_full || w_pop);
    assign w_drop    = w_event && w_full && !w_pop;

    assign w_wr_ptr_nxt = w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
    assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

    // When the entry being written becomes the new head (the FIFO is empty after
    // any pop), take it straight from the input. The memory write only lands on
    // this same edge, so reading the memory would return stale data.
    assign w_bypass   = w_push && (r_wr_ptr == w_rd_ptr_nxt);
    assign w_head_nxt = w_bypass ? w_entry : r_mem[w_rd_ptr_nxt[ADDR_W-1:0]];

    // Seeing HALT ends capture even when its own entry is dropped.
    assign w_state_nxt = (w_capture && cpu_halt) ? ST_HALTED : r_state;

    // Entry storage. It has no reset; validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_entry;
        end
    end

    // Capture FSM together with the pointers and the registered read-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_CAPTURE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ts       <= '0;
            r_shadow   <= '0;
            r_first    <= 1'b1;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_overflow <= 1'b0;
            r_dropped  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;

            // Cycle timestamp since reset release. It holds at all-ones.
            if (r_ts != '1) begin
                r_ts <= r_ts + TS_ONE;
            end

            if (w_event) begin
                r_shadow <= w_sample;
                r_first  <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropped != 8'hFF) begin
                    r_dropped <= r_dropped + 8'd1;
                end
            end

            // The head only changes on a pop, or when the first entry arrives in an
            // empty FIFO. This keeps rd_data stable while rd_valid && !rd_ready.
            r_rd_valid <= (w_count_nxt != '0);
            r_rd_data  <= w_head_nxt;
            r_done     <= (w_state_nxt == ST_HALTED) && (w_count_nxt == '0);
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign count    = w_count;
    assign overflow = r_overflow;
    assign dropped  = r_dropped;
    assign done     = r_done;

endmodule

// File: doc/cpu_out_tracer.md
Name: cpu_out_tracer

Overview:
- Downstream observer of the microprogrammed processor; samples `out[15:0]`, I, Z, S and HALT every clock.
- Logs each change as a timestamped entry in a FIFO.
- A host-side reader (bench or UART bridge) drains the FIFO over a valid/ready handshake.
- Capture stops once HALT is seen, so a program's complete output trace is preserved for checking.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, ≥2.
- ADDR_W, 4, log2(DEPTH).
- TS_W, 16, cycle-timestamp width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_out  input  16  processor `out` bus.
- cpu_i  input  1  processor I flag.
- cpu_z  input  1  processor Z flag.
- cpu_s  input  1  processor S flag.
- cpu_halt  input  1  processor HALT.
- rd_valid  output  1  FIFO head entry available.
- rd_ready  input  1  reader accepts head entry.
- rd_data  output  TS_W+20  entry = {timestamp[TS_W-1:0], halt, s, z, i, out[15:0]}.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: at least one entry dropped.
- dropped  output  8  number of dropped entries, saturating at 255.
- done  output  1  state HALTED and FIFO empty.

Behaviour:
- Async reset applies immediately, regardless of clk:
  - state=CAPTURE; FIFO empty; rd_valid=0; rd_data=0; count=0.
  - overflow=0; dropped=0; done=0.
  - timestamp=0; shadow register={out=0, flags=0, halt=0}; first_flag=1.
- Timestamp counts clocks since reset release, saturating at all-ones.
  - The value stored in an entry is the timestamp of the sampling edge.
- States:
  - CAPTURE: on each rising edge, sample inputs. An event occurs when first_flag=1 or {halt,s,z,i,out} differs from the shadow register.
    - On event: push entry, update shadow, clear first_flag.
    - If cpu_halt=1 is sampled, push its entry (event by definition, since halt changed) and go to HALTED next cycle.
  - HALTED: no further pushes; inputs ignored; the reader continues draining. Only reset leaves HALTED.
- Push/pop rules:
  - Pop occurs when rd_valid && rd_ready at an edge.
  - A push is accepted when count<DEPTH, or when count==DEPTH and a pop occurs on the same edge.
  - Simultaneous push and pop: count unchanged; order preserved.
  - Push when full with no pop: entry dropped, overflow set to 1 (sticky), dropped incremented (saturates at 255), shadow still updated so the same value is not re-logged.
  - If the halt entry itself is dropped, the state still moves to HALTED.
  - Pop when empty cannot occur (rd_valid=0).
- Read interface:
  - rd_data is the registered FIFO head.
  - rd_valid asserts the cycle after the first push into an empty FIFO (1-cycle write-to-read latency).
  - rd_data is held stable while rd_valid && !rd_ready.
- Pointers wrap modulo DEPTH. count is derived from an extra-bit pointer difference.
- done is registered: 1 when state==HALTED and count==0.
- Reset asserted mid-trace discards all entries and restarts capture, with first_flag set again.

Test Plan:
- Reset release, inputs constant (out=0x0000, flags 0), rd_ready=0, 10 cycles → exactly one entry {ts=0, 0,0,0,0, 0x0000}; count=1; rd_valid=1 from cycle 1.
- out steps 0x0003→0x0006→0x0012 at ts 2,5,9 with S=0, Z toggling with out (Z=1 at 0x0000 only), reader always ready → entries popped in order with timestamps 0,2,5,9 and matching values; count returns to 0.
- rd_ready=0, out changes every cycle for 20 cycles with DEPTH=16 → count=16; overflow=1; dropped=4 (first entry plus 15 changes stored, remaining changes dropped); the first 16 entries are intact.
- FIFO full with rd_ready=1 on the same edge as a new event → count stays 16, dropped unchanged, newest entry at the tail.
- Multiplication program ends with out=0x0018, HALT=1 at ts 40 → last entry {40, halt=1, …, 0x0018}; later out changes are not logged; done=1 after the final pop.
- Assert reset at ts 7 with 3 entries queued → count=0, rd_valid=0 immediately; after release the first entry has ts=0.
